// File: rtl/signature_loader_if.sv
// Line-load handshake, status and matrix read-port bundle shared by
// signature_loader and whoever feeds it training lines.
interface signature_loader_if #(
   parameter int NUM_CLUSTERS = 8,
   parameter int LINE_BITS    = 512,
   parameter int CNT_WIDTH    = 16
);
   logic                    in_valid;
   logic                    in_ready;
   logic [LINE_BITS-1:0]    in_line;
   logic [2:0]              in_cluster;
   logic                    clear_req;
   logic                    busy;
   logic                    done;
   logic [CNT_WIDTH-1:0]    load_count;
   logic [7:0]              rd1_addr;
   logic [NUM_CLUSTERS-1:0] rd1_data;
   logic [2:0]              rd2_cluster;
   logic [7:0]              rd2_hash;
   logic                    rd2_bit;

   modport master (
      output in_valid, in_line, in_cluster, clear_req, rd1_addr, rd2_cluster, rd2_hash,
      input  in_ready, busy, done, load_count, rd1_data, rd2_bit
   );

   modport slave (
      input  in_valid, in_line, in_cluster, clear_req, rd1_addr, rd2_cluster, rd2_hash,
      output in_ready, busy, done, load_count, rd1_data, rd2_bit
   );
endinterface

// File: rtl/signature_loader.sv
// Programs the two signature matrices from labelled cache lines: a line is hashed
// one byte per cycle (XOR fold and mod-256 sum) and committed as one bit per matrix.
module signature_loader #(
   parameter int NUM_CLUSTERS   = 8,
   parameter int AMPLITUDE_HASH = 256,
   parameter int LINE_BITS      = 512,
   parameter int CNT_WIDTH      = 16
) (
   input  logic              clk,
   input  logic              reset,
   signature_loader_if.slave bus
);
   localparam int                   NUM_BYTES = LINE_BITS / 8;
   localparam logic [7:0]           LAST_BYTE = 8'(NUM_BYTES - 1);
   localparam logic [7:0]           LAST_ROW  = 8'(AMPLITUDE_HASH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HASH   = 2'd1,
      COMMIT = 2'd2,
      CLEAR  = 2'd3
   } state_t;

   state_t                    state_r;
   state_t                    state_nx_s;
   logic [7:0]                cnt_r;
   logic [7:0]                acc_x_r;
   logic [7:0]                acc_s_r;
   logic [LINE_BITS-1:0]      line_r;
   logic [2:0]                cluster_r;
   logic [NUM_CLUSTERS-1:0]   first_matrix_r  [AMPLITUDE_HASH];
   logic [AMPLITUDE_HASH-1:0] second_matrix_r [NUM_CLUSTERS];
   logic [CNT_WIDTH-1:0]      load_count_r;
   logic                      busy_r;
   logic                      done_r;

   logic                      in_ready_s;
   logic                      accept_s;
   logic                      clear_start_s;
   logic                      hash_en_s;
   logic                      commit_en_s;
   logic                      clear_en_s;
   logic                      clear_last_s;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode; a clear request outranks a pending line in IDLE.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.clear_req) begin
               state_nx_s = CLEAR;
            end else if (bus.in_valid) begin
               state_nx_s = HASH;
            end else begin
               state_nx_s = IDLE;
            end
         end
         HASH: begin
            if (cnt_r == LAST_BYTE) begin
               state_nx_s = COMMIT;
            end else begin
               state_nx_s = HASH;
            end
         end
         COMMIT: begin
            state_nx_s = IDLE;
         end
         CLEAR: begin
            if (cnt_r == LAST_ROW) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = CLEAR;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Per-state datapath strobes and the ready indication.
   always_comb begin
      in_ready_s    = 1'b0;
      accept_s      = 1'b0;
      clear_start_s = 1'b0;
      hash_en_s     = 1'b0;
      commit_en_s   = 1'b0;
      clear_en_s    = 1'b0;
      clear_last_s  = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready_s = ~reset;
            if (bus.clear_req) begin
               clear_start_s = 1'b1;
            end else if (bus.in_valid) begin
               accept_s = 1'b1;
            end else begin
               accept_s = 1'b0;
            end
         end
         HASH: begin
            hash_en_s = 1'b1;
         end
         COMMIT: begin
            commit_en_s = 1'b1;
         end
         CLEAR: begin
            clear_en_s   = 1'b1;
            clear_last_s = (cnt_r == LAST_ROW);
         end
         default: begin
            in_ready_s = 1'b0;
         end
      endcase
   end

   // Line capture and serial hashing; the latched line shifts down so byte k
   // sits in the low byte on the k-th hash cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r     <= 8'd0;
         acc_x_r   <= 8'd0;
         acc_s_r   <= 8'd0;
         line_r    <= '0;
         cluster_r <= 3'd0;
      end else begin
         if (accept_s || clear_start_s) begin
            cnt_r <= 8'd0;
         end else if (hash_en_s || clear_en_s) begin
            cnt_r <= cnt_r + 8'd1;
         end

         if (accept_s) begin
            line_r    <= bus.in_line;
            cluster_r <= bus.in_cluster;
            acc_x_r   <= 8'd0;
            acc_s_r   <= 8'd0;
         end else if (hash_en_s) begin
            acc_x_r <= acc_x_r ^ line_r[7:0];
            acc_s_r <= acc_s_r + line_r[7:0];
            line_r  <= line_r >> 4'd8;
         end
      end
   end

   // Matrix storage: set-only commits, one row/column per cycle during clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int h = 0; h < AMPLITUDE_HASH; h++) begin
            first_matrix_r[h] <= '0;
         end
         for (int c = 0; c < NUM_CLUSTERS; c++) begin
            second_matrix_r[c] <= '0;
         end
      end else if (commit_en_s) begin
         first_matrix_r[acc_x_r][cluster_r]  <= 1'b1;
         second_matrix_r[cluster_r][acc_s_r] <= 1'b1;
      end else if (clear_en_s) begin
         first_matrix_r[cnt_r] <= '0;
         for (int c = 0; c < NUM_CLUSTERS; c++) begin
            second_matrix_r[c][cnt_r] <= 1'b0;
         end
      end
   end

   // Status outputs: busy follows the next state so it rises with the accept edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         load_count_r <= '0;
      end else begin
         busy_r <= (state_nx_s != IDLE);
         done_r <= commit_en_s | clear_last_s;
         if (clear_last_s) begin
            load_count_r <= '0;
         end else if (commit_en_s && (load_count_r != CNT_MAX)) begin
            load_count_r <= load_count_r + CNT_ONE;
         end
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.load_count = load_count_r;
   assign bus.rd1_data   = first_matrix_r[bus.rd1_addr];
   assign bus.rd2_bit    = second_matrix_r[bus.rd2_cluster][bus.rd2_hash];

endmodule

// File: tb/tb_signature_loader.sv
// Self-checking bench for signature_loader: hand-computed vector table, clear and
// reset corner sequences, then random lines checked against a hash/matrix model.
module tb_signature_loader;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   signature_loader_if #(.NUM_CLUSTERS(8), .LINE_BITS(512), .CNT_WIDTH(16)) bus ();

   signature_loader #(
      .NUM_CLUSTERS(8), .AMPLITUDE_HASH(256), .LINE_BITS(512), .CNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // Reference model: the matrices as plain bit arrays plus a line counter.
   logic [7:0]   fm_m [256];
   logic [255:0] sm_m [8];
   int           lc_m;
   int           n_checks = 0;
   int           n_pass   = 0;

   typedef struct {
      logic [511:0] line;
      logic [2:0]   cluster;
      bit           scramble;
      logic [7:0]   rd1_addr;
      logic [7:0]   rd1_exp;
      logic [2:0]   rda_c;
      logic [7:0]   rda_h;
      logic         rda_exp;
      logic [2:0]   rdb_c;
      logic [7:0]   rdb_h;
      logic         rdb_exp;
      logic [15:0]  lc_exp;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic void line_hash(input logic [511:0] line, output logic [7:0] x,
                                     output logic [7:0] s);
      int sum;
      sum = 0;
      x   = 8'h00;
      for (int k = 0; k < 64; k++) begin
         x   = x ^ line[8*k +: 8];
         sum = sum + int'(line[8*k +: 8]);
      end
      s = 8'(sum % 256);
   endfunction

   task automatic model_clear();
      for (int h = 0; h < 256; h++) fm_m[h] = 8'h00;
      for (int c = 0; c < 8; c++) sm_m[c] = '0;
      lc_m = 0;
   endtask

   task automatic model_load(input logic [511:0] line, input logic [2:0] cl);
      logic [7:0] x;
      logic [7:0] s;
      line_hash(line, x, s);
      fm_m[x][cl] = 1'b1;
      sm_m[cl][s] = 1'b1;
      if (lc_m < 65535) lc_m++;
   endtask

   function automatic logic [511:0] rand_line();
      logic [511:0] l;
      for (int w = 0; w < 16; w++) l[32*w +: 32] = $urandom;
      if ($urandom_range(0, 3) == 0) l = l & {16{32'h000000FF}};
      return l;
   endfunction

   // Waits (bounded) for done; returns the negedge index it appeared at, counting
   // cycles before it where in_ready was high or busy was low.
   task automatic wait_done(input int budget, input bit scramble, output int lat,
                            output int ready_hi, output int busy_lo);
      lat      = -1;
      ready_hi = 0;
      busy_lo  = 0;
      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = n;
            break;
         end
         if (bus.in_ready) ready_hi++;
         if (!bus.busy) busy_lo++;
         if (scramble && n < 60) begin
            bus.in_line    = rand_line();
            bus.in_cluster = 3'($urandom_range(0, 7));
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.clear_req  = 1'($urandom_range(0, 1));
         end else begin
            bus.in_valid  = 1'b0;
            bus.clear_req = 1'b0;
         end
      end
   endtask

   task automatic load_line(input logic [511:0] line, input logic [2:0] cl,
                            input bit scramble, input string tag);
      int lat, rh, bl;
      check({tag, "_ready_before"}, bus.in_ready, 1);
      bus.in_line    = line;
      bus.in_cluster = cl;
      bus.in_valid   = 1'b1;
      bus.clear_req  = 1'b0;
      wait_done(200, scramble, lat, rh, bl);
      check({tag, "_done_latency"}, lat, 66);
      check({tag, "_ready_low_in_hash"}, rh, 0);
      check({tag, "_busy_high_in_hash"}, bl, 0);
      check({tag, "_ready_at_done"}, bus.in_ready, 1);
      model_load(line, cl);
   endtask

   task automatic sweep(input string tag);
      int bad1, bad2;
      bad1 = 0;
      bad2 = 0;
      for (int a = 0; a < 256; a++) begin
         bus.rd1_addr = 8'(a);
         #1;
         if (bus.rd1_data !== fm_m[a]) bad1++;
      end
      for (int c = 0; c < 8; c++) begin
         for (int h = 0; h < 256; h++) begin
            bus.rd2_cluster = 3'(c);
            bus.rd2_hash    = 8'(h);
            #1;
            if (bus.rd2_bit !== sm_m[c][h]) bad2++;
         end
      end
      check({tag, "_rd1_bad_entries"}, bad1, 0);
      check({tag, "_rd2_bad_entries"}, bad2, 0);
      check({tag, "_load_count"}, bus.load_count, 64'(lc_m));
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0] ln;
      logic [7:0]   x, s;
      int           lat, rh, bl, dcount;

      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_line = '0; bus.in_cluster = 3'd0; bus.clear_req = 1'b0;
      bus.rd1_addr = 8'd0; bus.rd2_cluster = 3'd0; bus.rd2_hash = 8'd0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_load_count", bus.load_count, 0);
      reset = 1'b0;
      model_clear();
      @(negedge clk);
      check("post_rst_ready", bus.in_ready, 1);

      // Hand-computed vectors; cumulative, so order matters.
      ln = '0;
      vecs[0] = '{ln, 3'd0, 1'b0, 8'h00, 8'h01, 3'd0, 8'h00, 1'b1, 3'd0, 8'h01, 1'b0, 16'd1};
      ln = '0; ln[7:0] = 8'h05; ln[15:8] = 8'h03;
      vecs[1] = '{ln, 3'd5, 1'b0, 8'h06, 8'h20, 3'd5, 8'h08, 1'b1, 3'd5, 8'h06, 1'b0, 16'd2};
      ln = {512{1'b1}};
      vecs[2] = '{ln, 3'd7, 1'b0, 8'h00, 8'h81, 3'd7, 8'hC0, 1'b1, 3'd7, 8'h00, 1'b0, 16'd3};
      ln = '0; ln[511:504] = 8'h80;
      vecs[3] = '{ln, 3'd3, 1'b1, 8'h80, 8'h08, 3'd3, 8'h80, 1'b1, 3'd3, 8'h00, 1'b0, 16'd4};
      ln = '0; ln[7:0] = 8'hAA; ln[15:8] = 8'hAA;
      vecs[4] = '{ln, 3'd2, 1'b0, 8'h00, 8'h85, 3'd2, 8'h54, 1'b1, 3'd0, 8'h00, 1'b1, 16'd5};

      for (int i = 0; i < 5; i++) begin
         load_line(vecs[i].line, vecs[i].cluster, vecs[i].scramble, $sformatf("vec%0d", i));
         bus.rd1_addr    = vecs[i].rd1_addr;
         bus.rd2_cluster = vecs[i].rda_c;
         bus.rd2_hash    = vecs[i].rda_h;
         #1;
         check($sformatf("vec%0d_rd1", i), bus.rd1_data, vecs[i].rd1_exp);
         check($sformatf("vec%0d_rd2a", i), bus.rd2_bit, vecs[i].rda_exp);
         bus.rd2_cluster = vecs[i].rdb_c;
         bus.rd2_hash    = vecs[i].rdb_h;
         #1;
         check($sformatf("vec%0d_rd2b", i), bus.rd2_bit, vecs[i].rdb_exp);
         check($sformatf("vec%0d_load_count", i), bus.load_count, vecs[i].lc_exp);
      end
      sweep("table");

      // Clear and a line offered in the same IDLE cycle: clear wins.
      check("clr_ready_before", bus.in_ready, 1);
      ln = '0; ln[7:0] = 8'h11;
      bus.in_line = ln; bus.in_cluster = 3'd6; bus.in_valid = 1'b1; bus.clear_req = 1'b1;
      wait_done(400, 1'b0, lat, rh, bl);
      check("clr_done_latency", lat, 257);
      check("clr_ready_low", rh, 0);
      check("clr_busy_high", bl, 0);
      check("clr_ready_at_done", bus.in_ready, 1);
      model_clear();
      sweep("clear");

      // Reset in the middle of hashing aborts the line.
      load_line(rand_line(), 3'd1, 1'b0, "pre_rst_a");
      load_line(rand_line(), 3'd4, 1'b0, "pre_rst_b");
      bus.in_line = rand_line(); bus.in_cluster = 3'd6; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (29) @(negedge clk);
      check("midrst_busy_before", bus.busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_ready_in_reset", bus.in_ready, 0);
      check("midrst_busy_in_reset", bus.busy, 0);
      reset = 1'b0;
      model_clear();
      @(negedge clk);
      check("midrst_ready_after", bus.in_ready, 1);
      dcount = 0;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         if (bus.done) dcount++;
      end
      check("midrst_no_done", dcount, 0);
      sweep("midrst");

      // Random back-to-back lines, some with inputs scrambled during hashing.
      for (int i = 0; i < 30; i++) begin
         ln = rand_line();
         load_line(ln, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                   $sformatf("rnd%0d", i));
         line_hash(ln, x, s);
         bus.rd1_addr    = x;
         bus.rd2_cluster = bus.in_cluster;
         bus.rd2_hash    = s;
         #1;
         check($sformatf("rnd%0d_rd1", i), bus.rd1_data, fm_m[x]);
         check($sformatf("rnd%0d_load_count", i), bus.load_count, 64'(lc_m));
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      sweep("random");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
